// File: rtl/fibonacci_seq.sv
// fibonacci_seq: paced Fibonacci term generator with valid/ready output.
// One term is emitted every TICK_DIV counted cycles; the term is held until
// accepted. The largest representable term is flagged with f_last.
// Optional feature macro FIB_SATURATE_EN: stop in DONE after the last term
// is accepted instead of restarting the sequence at 0.
module fibonacci_seq #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_en,
  input  logic             f_load,
  input  logic             f_ready,
  output logic             f_valid,
  output logic [WIDTH-1:0] f_out,
  output logic             f_last
);

  localparam int             CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  // Carry out of a+b marks b as the last term that fits in WIDTH bits.
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // Next-state logic: f_load overrides every state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    wrap_d  = wrap_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (f_load) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = WIDTH'(1);
      wrap_d  = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          valid_d = 1'b0;
          if (f_en) state_d = COUNT;
        end
        COUNT: begin
          if (!f_en) begin
            // Pause: keep the term pair so nothing is skipped on resume.
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d   = '0;
            out_d   = a_q;
            valid_d = 1'b1;
            last_d  = wrap_q;
            state_d = HOLD;
            if (wrap_q) begin
              a_d    = '0;
              b_d    = WIDTH'(1);
              wrap_d = 1'b0;
            end else begin
              a_d    = b_q;
              b_d    = sum[WIDTH-1:0];
              wrap_d = sum[WIDTH];
            end
          end
        end
        HOLD: begin
          if (f_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
`ifdef FIB_SATURATE_EN
            if (last_q) state_d = DONE;
            else        state_d = f_en ? COUNT : IDLE;
`else
            state_d = f_en ? COUNT : IDLE;
`endif
          end
        end
        DONE: begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= WIDTH'(1);
      out_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign f_valid = valid_q;
  assign f_out   = out_q;
  assign f_last  = last_q;

endmodule

// File: tb/tb_fibonacci_seq.sv
// Scoreboard bench for fibonacci_seq: two instances (16-bit/div 1, 8-bit/div 3).
module tb_fibonacci_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_load, a_ready, a_valid, a_last;
  logic [15:0] a_out;
  logic        b_en, b_load, b_ready, b_valid, b_last;
  logic [7:0]  b_out;

  fibonacci_seq #(.WIDTH(16), .TICK_DIV(1)) u_a (
    .clk(clk), .rst(rst), .f_en(a_en), .f_load(a_load), .f_ready(a_ready),
    .f_valid(a_valid), .f_out(a_out), .f_last(a_last)
  );

  fibonacci_seq #(.WIDTH(8), .TICK_DIV(3)) u_b (
    .clk(clk), .rst(rst), .f_en(b_en), .f_load(b_load), .f_ready(b_ready),
    .f_valid(b_valid), .f_out(b_out), .f_last(b_last)
  );

  typedef struct {
    int unsigned v;
    bit          last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;
  int   gap_a = 0;
  int   gap_b = 0;
  time  lt_a  = 0;
  time  lt_b  = 0;

  int unsigned fib16 [25] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233,
                              377, 610, 987, 1597, 2584, 4181, 6765, 10946,
                              17711, 28657, 46368};
  int unsigned fib8 [14]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

  function automatic void check(input string name, input int unsigned act,
                                input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push_a(input int unsigned v, input bit l);
    exp_t e;
    e.v = v; e.last = l;
    qa.push_back(e);
  endfunction

  function automatic void push_b(input int unsigned v, input bit l);
    exp_t e;
    e.v = v; e.last = l;
    qb.push_back(e);
  endfunction

  // Monitor A: each new presentation (rising f_valid) pops one expectation.
  initial begin : mon_a
    bit pv;
    pv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (a_valid && !pv) begin
        if (qa.size() == 0) begin
          check("a_extra_term", a_out, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = qa.pop_front();
          check("a_term", a_out, e.v);
          check("a_last", a_last, e.last);
          if (gap_a != 0 && lt_a != 0) check("a_gap", int'(($time - lt_a) / 10), gap_a);
          lt_a = $time;
        end
      end
      pv = a_valid;
    end
  end

  // Monitor B.
  initial begin : mon_b
    bit pv;
    pv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (b_valid && !pv) begin
        if (qb.size() == 0) begin
          check("b_extra_term", b_out, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = qb.pop_front();
          check("b_term", b_out, e.v);
          check("b_last", b_last, e.last);
          if (gap_b != 0 && lt_b != 0) check("b_gap", int'(($time - lt_b) / 10), gap_b);
          lt_b = $time;
        end
      end
      pv = b_valid;
    end
  end

  task automatic wait_empty_a(input int bound);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (qa.size() != 0 && n < bound);
    check("a_drain", qa.size(), 0);
    qa.delete();
  endtask

  task automatic wait_empty_b(input int bound);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (qb.size() != 0 && n < bound);
    check("b_drain", qb.size(), 0);
    qb.delete();
  endtask

  task automatic wait_valid_a(input int bound);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_valid && n < bound);
    check("a_valid_seen", a_valid, 1);
  endtask

  task automatic accept_a();
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
  endtask

  initial begin : stim
    int cnt;
    rst = 1'b0;
    a_en = 1'b0; a_load = 1'b0; a_ready = 1'b0;
    b_en = 1'b0; b_load = 1'b0; b_ready = 1'b0;
    #12;
    check("rst_a_valid", a_valid, 0);
    check("rst_a_out", a_out, 0);
    check("rst_a_last", a_last, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_out", b_out, 0);
    @(negedge clk) rst = 1'b1;

    // A: sustained run through the 16-bit wrap point.
    for (int i = 0; i < 25; i++) push_a(fib16[i], i == 24);
    push_a(0, 0); push_a(1, 0); push_a(1, 0);
    gap_a = 2; lt_a = 0;
    @(negedge clk); a_en = 1'b1; a_ready = 1'b1;
    @(posedge clk); #1 check("a_lat_edge1", a_valid, 0);
    @(posedge clk); #1 check("a_lat_edge2", a_valid, 1);
    wait_empty_a(200);
    gap_a = 0;
    a_en = 1'b0; a_load = 1'b1;
    @(negedge clk); a_load = 1'b0; a_ready = 1'b0;
    check("a_after_load_valid", a_valid, 0);

    // A: backpressure, pause, load during HOLD.
    a_en = 1'b1;
    push_a(0, 0); push_a(1, 0); push_a(1, 0); push_a(2, 0); push_a(3, 0);
    for (int i = 0; i < 5; i++) begin
      wait_valid_a(20);
      if (i == 4) begin
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        a_en = 1'b0;
      end else begin
        accept_a();
      end
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_valid) cnt++;
    end
    check("a_pause_no_valid", cnt, 0);
    push_a(5, 0);
    a_en = 1'b1;
    wait_valid_a(20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("a_hold_out", a_out, 5);
      check("a_hold_valid", a_valid, 1);
    end
    push_a(8, 0);
    accept_a();
    wait_valid_a(20);
    push_a(0, 0);
    a_load = 1'b1;
    @(negedge clk);
    check("a_load_in_hold", a_valid, 0);
    a_load = 1'b0;
    wait_valid_a(20);
    push_a(1, 0);
    accept_a();
    wait_valid_a(20);

    // A: async reset between edges while holding term 1.
    #2 rst = 1'b0;
    #1;
    check("a_async_valid", a_valid, 0);
    check("a_async_out", a_out, 0);
    check("a_async_last", a_last, 0);
    @(negedge clk);
    push_a(0, 0);
    rst = 1'b1; a_ready = 1'b1;
    wait_empty_a(50);
    a_en = 1'b0;
    @(negedge clk); a_ready = 1'b0;

    // B: 8-bit run, TICK_DIV=3.
    for (int i = 0; i < 14; i++) push_b(fib8[i], i == 13);
`ifndef FIB_SATURATE_EN
    push_b(0, 0); push_b(1, 0); push_b(1, 0);
`endif
    gap_b = 4; lt_b = 0;
    @(negedge clk); b_en = 1'b1; b_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1 check("b_latency", b_valid, (k == 4) ? 1 : 0);
    end
    wait_empty_b(300);
`ifdef FIB_SATURATE_EN
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_valid) cnt++;
    end
    check("b_done_no_valid", cnt, 0);
    gap_b = 0;
    push_b(0, 0);
    b_load = 1'b1;
    @(negedge clk); b_load = 1'b0;
    wait_empty_b(50);
`endif
    b_en = 1'b0;
    repeat (10) @(negedge clk);
    check("a_queue_left", qa.size(), 0);
    check("b_queue_left", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
